// File: rtl/tsd_adc_emulator_pkg.sv
// tsd_emu_pkg: shared definitions for the sense-diode ADC emulator.
//   tsd_state_e    - conversion FSM states
//   TSD_OFFSET     - raw code offset (code = deg C + TSD_OFFSET)
//   TSD_INVALID    - tsdcalo value before any conversion has completed
//   TSD_MAX_VALID  - largest code ever reported as a valid result
//   tsd_cnt_width  - bit-window counter width for a given cycles-per-bit
package tsd_emu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONVERT,
    S_DONE
  } tsd_state_e;

  localparam int unsigned TSD_OFFSET    = 133;
  localparam logic [7:0]  TSD_INVALID   = 8'hFF;
  localparam logic [7:0]  TSD_MAX_VALID = 8'd254;

  // ceil(log2(n)), never less than 1 so a 1-cycle window still gets a counter.
  function automatic int unsigned tsd_cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 0; i < 5; i++) begin
      if ((32'd1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/tsd_adc_emulator_if.sv
// tsd_adc_emulator_if: sense-diode control interface between a temperature
// reader (master) and the ADC block or its emulator (slave).
//   ce, clr     - enable and clear/arm from the reader (polarity set by slave)
//   temp_code   - emulated raw temperature code fed to the emulator
//   tsdcalo     - 8-bit conversion result
//   tsdcaldone  - result valid
interface tsd_adc_emulator_if;

  logic       ce;
  logic       clr;
  logic [7:0] temp_code;
  logic [7:0] tsdcalo;
  logic       tsdcaldone;

  modport master (
    output ce,
    output clr,
    output temp_code,
    input  tsdcalo,
    input  tsdcaldone
  );

  modport slave (
    input  ce,
    input  clr,
    input  temp_code,
    output tsdcalo,
    output tsdcaldone
  );

endinterface

// File: rtl/tsd_adc_emulator_lfsr8.sv
// tsd_emu_lfsr8: 8-bit maximal-length Galois LFSR, x^8+x^6+x^5+x^4+1.
//   clk   - clock
//   rst_n - synchronous active-low reset, loads SEED
//   step  - advance one position
//   q     - current register value
module tsd_emu_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  // Right-shifting Galois form: feedback mask 8'hB8 covers taps 8,6,5,4.
  always_comb begin
    q_d = q_q;
    if (step) q_d = {1'b0, q_q[7:1]} ^ (q_q[0] ? 8'hB8 : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= SEED;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/tsd_adc_emulator.sv
// tsd_adc_emulator: synthesizable stand-in for the on-die temperature-sense
// diode ADC. Answers clr/ce from a reader with an 8-bit code after the same
// successive-approximation latency as the hard block (2 + 8*CYCLES_PER_BIT
// cycles from the start edge to tsdcaldone).
//   clk    - conversion clock
//   rst_n  - synchronous reset, active-low
//   bus    - slave side of tsd_adc_emulator_if (ce, clr, temp_code in;
//            tsdcalo, tsdcaldone out, both registered)
module tsd_adc_emulator
  import tsd_emu_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BIT  = 16,
  parameter bit          CE_ACTIVE_HIGH  = 1'b1,
  parameter bit          CLR_ACTIVE_HIGH = 1'b1,
  parameter bit          DITHER_EN       = 1'b0,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tsd_adc_emulator_if.slave    bus
);

  localparam int unsigned   CW       = tsd_cnt_width(CYCLES_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES_PER_BIT - 1);

  tsd_state_e    state_q;
  logic          armed_q;
  logic          done_q;
  logic [7:0]    code_q;
  logic [7:0]    target_q;
  logic [7:0]    result_q;
  logic [2:0]    idx_q;
  logic [CW-1:0] cnt_q;

  logic          ce_act;
  logic          clr_act;
  logic          sampling;
  logic [7:0]    lfsr_q;
  logic [7:0]    target_d;
  logic [7:0]    trial;
  logic signed [9:0] dither;
  logic signed [9:0] sum;

  assign ce_act  = CE_ACTIVE_HIGH  ? bus.ce  : !bus.ce;
  assign clr_act = CLR_ACTIVE_HIGH ? bus.clr : !bus.clr;

  // Only a SAMPLE cycle that actually captures a target advances the LFSR.
  assign sampling = (state_q == S_SAMPLE) && ce_act && !clr_act;

  tsd_emu_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (sampling && DITHER_EN),
    .q     (lfsr_q)
  );

  // Dither from the two LSBs: 01 -> +1, 10 -> -1, else 0. The sum is
  // clamped to 0..254 so 255 stays reserved as the invalid marker.
  always_comb begin
    dither = '0;
    if (DITHER_EN) begin
      case (lfsr_q & 8'h03)
        8'h01:   dither = 10'sd1;
        8'h02:   dither = -10'sd1;
        default: dither = '0;
      endcase
    end
    sum = $signed({2'b00, bus.temp_code}) + dither;
    if (sum < 10'sd0)
      target_d = '0;
    else if (sum > $signed({2'b00, TSD_MAX_VALID}))
      target_d = TSD_MAX_VALID;
    else
      target_d = sum[7:0];
  end

  assign trial = result_q | (8'd1 << idx_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      armed_q  <= 1'b0;
      done_q   <= 1'b0;
      code_q   <= TSD_INVALID;
      target_q <= '0;
      result_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else if (clr_act) begin
      state_q <= S_IDLE;
      armed_q <= 1'b1;
      done_q  <= 1'b0;
    end else if (!ce_act) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (armed_q) begin
            state_q <= S_SAMPLE;
            armed_q <= 1'b0;
          end
        end
        S_SAMPLE: begin
          target_q <= target_d;
          result_q <= '0;
          idx_q    <= 3'd7;
          cnt_q    <= '0;
          state_q  <= S_CONVERT;
        end
        S_CONVERT: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (trial <= target_q) result_q <= trial;
            if (idx_q == 3'd0) state_q <= S_DONE;
            else               idx_q   <= idx_q - 3'd1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          // Result and valid are published together on the first DONE cycle,
          // so tsdcalo never shows a partially decided code.
          code_q <= result_q;
          done_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.tsdcalo    = code_q;
  assign bus.tsdcaldone = done_q;

endmodule

// File: tb/tb_tsd_adc_emulator.sv
module tb_tsd_adc_emulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce_r  [4];
  logic       clr_r [4];
  logic [7:0] tc    [4];
  logic [7:0] lo    [4];
  logic       dn    [4];

  int vectors = 0;
  int errs    = 0;
  int seq [200];
  bit seen99, seen100, seen101;

  always #5 clk = ~clk;

  // 0: defaults, 1: inverted ce/clr polarity, 2: dither with 1 cycle/bit,
  // 3: 1 cycle/bit without dither
  tsd_adc_emulator_if if0 ();
  tsd_adc_emulator_if if1 ();
  tsd_adc_emulator_if if2 ();
  tsd_adc_emulator_if if3 ();

  assign if0.ce = ce_r[0]; assign if0.clr = clr_r[0]; assign if0.temp_code = tc[0];
  assign if1.ce = ce_r[1]; assign if1.clr = clr_r[1]; assign if1.temp_code = tc[1];
  assign if2.ce = ce_r[2]; assign if2.clr = clr_r[2]; assign if2.temp_code = tc[2];
  assign if3.ce = ce_r[3]; assign if3.clr = clr_r[3]; assign if3.temp_code = tc[3];
  assign lo[0] = if0.tsdcalo; assign dn[0] = if0.tsdcaldone;
  assign lo[1] = if1.tsdcalo; assign dn[1] = if1.tsdcaldone;
  assign lo[2] = if2.tsdcalo; assign dn[2] = if2.tsdcaldone;
  assign lo[3] = if3.tsdcalo; assign dn[3] = if3.tsdcaldone;

  tsd_adc_emulator u_nom (
    .clk (clk), .rst_n (rst_n), .bus (if0.slave)
  );

  tsd_adc_emulator #(
    .CE_ACTIVE_HIGH  (1'b0),
    .CLR_ACTIVE_HIGH (1'b0)
  ) u_pol (
    .clk (clk), .rst_n (rst_n), .bus (if1.slave)
  );

  tsd_adc_emulator #(
    .CYCLES_PER_BIT (1),
    .DITHER_EN      (1'b1),
    .LFSR_SEED      (8'hA5)
  ) u_dith (
    .clk (clk), .rst_n (rst_n), .bus (if2.slave)
  );

  tsd_adc_emulator #(
    .CYCLES_PER_BIT (1)
  ) u_fast (
    .clk (clk), .rst_n (rst_n), .bus (if3.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Instance 1 uses active-low ce/clr; everything else active-high.
  function automatic logic lvl(input int k, input logic act);
    return (k == 1) ? !act : act;
  endfunction

  // Returns just after the clear edge; the next edge is the start edge.
  task automatic clr_pulse(input int k);
    clr_r[k] = lvl(k, 1'b1);
    tick();
    clr_r[k] = lvl(k, 1'b0);
  endtask

  // Called right after clr_pulse: done must still be low after edge
  // T+lat-1 and high with the expected code after edge T+lat.
  task automatic wait_done(input int k, input int lat, input logic [7:0] exp);
    repeat (lat) tick();
    check($sformatf("done_early_%0d", k), dn[k], 1'b0);
    tick();
    check($sformatf("done_%0d", k), dn[k], 1'b1);
    check($sformatf("code_%0d", k), lo[k], exp);
  endtask

  task automatic run_conv(input int k, input logic [7:0] t, input int lat, input logic [7:0] exp);
    tc[k] = t;
    clr_pulse(k);
    wait_done(k, lat, exp);
  endtask

  initial begin
    ce_r  = '{1'b0, 1'b1, 1'b0, 1'b0};
    clr_r = '{1'b0, 1'b1, 1'b0, 1'b0};
    tc    = '{8'd0, 8'd0, 8'd0, 8'd0};
    rst_n = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_code_%0d", k), lo[k], 8'hFF);
      check($sformatf("rst_done_%0d", k), dn[k], 1'b0);
    end
    rst_n = 1'b1;

    // Enabled but never armed: no conversion.
    ce_r[0] = 1'b1;
    tc[0]   = 8'd158;
    repeat (200) tick();
    check("no_arm_done", dn[0], 1'b0);
    check("no_arm_code", lo[0], 8'hFF);

    // Nominal 25 C conversion, then hold.
    run_conv(0, 8'd158, 130, 8'd158);
    repeat (50) tick();
    check("hold_done", dn[0], 1'b1);
    check("hold_code", lo[0], 8'd158);

    // Next clr drops done but keeps code; temp change after SAMPLE ignored.
    tc[0] = 8'd0;
    clr_pulse(0);
    check("clr_done", dn[0], 1'b0);
    check("clr_code", lo[0], 8'd158);
    repeat (2) tick();
    tc[0] = 8'd99;
    repeat (128) tick();
    check("zero_early", dn[0], 1'b0);
    tick();
    check("zero_done", dn[0], 1'b1);
    check("zero_code", lo[0], 8'd0);

    run_conv(0, 8'd254, 130, 8'd254);
    run_conv(0, 8'd255, 130, 8'd254);

    // clr in the middle of CONVERT restarts the conversion.
    tc[0] = 8'd50;
    clr_pulse(0);
    repeat (62) tick();
    clr_pulse(0);
    check("abort_done", dn[0], 1'b0);
    check("abort_code", lo[0], 8'd254);
    wait_done(0, 130, 8'd50);

    // ce dropped mid-convert: idle, no restart without a new clr.
    tc[0] = 8'd60;
    clr_pulse(0);
    repeat (40) tick();
    ce_r[0] = 1'b0;
    tick();
    check("ce_drop_done", dn[0], 1'b0);
    ce_r[0] = 1'b1;
    repeat (200) tick();
    check("ce_reen_done", dn[0], 1'b0);
    check("ce_reen_code", lo[0], 8'd50);
    run_conv(0, 8'd60, 130, 8'd60);

    // clr and !ce together: armed, start waits for ce.
    tc[0]    = 8'd77;
    clr_r[0] = 1'b1;
    ce_r[0]  = 1'b0;
    tick();
    check("simul_done", dn[0], 1'b0);
    clr_r[0] = 1'b0;
    repeat (5) tick();
    check("simul_wait_done", dn[0], 1'b0);
    check("simul_wait_code", lo[0], 8'd60);
    ce_r[0] = 1'b1;
    wait_done(0, 130, 8'd77);
    ce_r[0] = 1'b0;

    // Inverted polarity with inverted stimulus matches nominal.
    ce_r[1] = 1'b0;
    run_conv(1, 8'd158, 130, 8'd158);
    // Un-inverted stimulus: never done.
    ce_r[1]  = 1'b1;
    clr_r[1] = 1'b0;
    tick();
    check("pol_off_done", dn[1], 1'b0);
    clr_r[1] = 1'b1;
    tick();
    clr_r[1] = 1'b0;
    repeat (300) tick();
    check("pol_uninv_done", dn[1], 1'b0);
    check("pol_uninv_code", lo[1], 8'd158);

    // One cycle per bit.
    ce_r[3] = 1'b1;
    run_conv(3, 8'd200, 10, 8'd200);
    run_conv(3, 8'd255, 10, 8'd254);

    // Dither: 200 conversions of code 100.
    ce_r[2] = 1'b1;
    tc[2]   = 8'd100;
    seen99 = 1'b0; seen100 = 1'b0; seen101 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      clr_pulse(2);
      repeat (10) tick();
      check("dith_early", dn[2], 1'b0);
      tick();
      check("dith_done", dn[2], 1'b1);
      seq[i] = int'(lo[2]);
      check("dith_range", (seq[i] >= 99 && seq[i] <= 101), 1'b1);
      if (seq[i] == 99)  seen99  = 1'b1;
      if (seq[i] == 100) seen100 = 1'b1;
      if (seq[i] == 101) seen101 = 1'b1;
    end
    // Seed A5 -> EA -> 75 -> 82: LSB pairs 01,10,01,10.
    check("dith_seq0", seq[0], 101);
    check("dith_seq1", seq[1], 99);
    check("dith_seq2", seq[2], 101);
    check("dith_seq3", seq[3], 99);
    check("dith_seen99", seen99, 1'b1);
    check("dith_seen100", seen100, 1'b1);
    check("dith_seen101", seen101, 1'b1);

    // Same seed after reset reproduces the sequence.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      clr_pulse(2);
      repeat (11) tick();
      check("dith_repeat", lo[2], seq[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
